// File: rtl/tile_spawner.sv
// 2048 tile spawner: detects a changed board, drops a new tile into an LFSR-chosen
// empty cell, then evaluates win/lose. Optional macro SPAWN_FOUR_EN enables 4-tiles.
module tile_spawner #(
  parameter int          VAL_W     = 12,
  parameter int          WIN_VALUE = 2048,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0][3:0][VAL_W-1:0]  matrix_in,
  input  logic [3:0][3:0][VAL_W-1:0]  matrix_prev,
  output logic [3:0][3:0][VAL_W-1:0]  matrix_out,
  output logic                        done,
  output logic                        busy,
  output logic                        spawned,
  output logic                        win,
  output logic                        lose
);

  typedef enum logic [2:0] {IDLE, CHECK, SCAN, PLACE, EVAL, DONE} state_t;

  state_t                       state;
  logic [3:0][3:0][VAL_W-1:0]   work;
  logic [3:0][3:0][VAL_W-1:0]   prev_r;
  logic [3:0]                   ptr;
  logic [15:0]                  lfsr;
  logic                         has_zero;
  logic                         has_win;
  logic                         has_pair;
  logic [VAL_W-1:0]             cur_cell;
`ifdef SPAWN_FOUR_EN
  logic                         val_sel;
`endif

  assign matrix_out = work;
  assign cur_cell   = work[ptr[3:2]][ptr[1:0]];

  always_comb begin
    has_zero = 1'b0;
    has_win  = 1'b0;
    has_pair = 1'b0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (work[2'(r)][2'(c)] == '0) has_zero = 1'b1;
        if (work[2'(r)][2'(c)] == VAL_W'(WIN_VALUE)) has_win = 1'b1;
      end
    end
    // 12 horizontal plus 12 vertical adjacencies
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        if (work[2'(r)][2'(c)] == work[2'(r)][2'(c + 1)]) has_pair = 1'b1;
        if (work[2'(c)][2'(r)] == work[2'(c + 1)][2'(r)]) has_pair = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      work    <= '0;
      prev_r  <= '0;
      ptr     <= '0;
      lfsr    <= LFSR_SEED;
      done    <= 1'b0;
      busy    <= 1'b0;
      spawned <= 1'b0;
      win     <= 1'b0;
      lose    <= 1'b0;
`ifdef SPAWN_FOUR_EN
      val_sel <= 1'b0;
`endif
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (state)
        IDLE: begin
          if (start) begin
            work    <= matrix_in;
            prev_r  <= matrix_prev;
            ptr     <= lfsr[3:0];
`ifdef SPAWN_FOUR_EN
            val_sel <= (lfsr[7:5] == 3'd0);
`endif
            spawned <= 1'b0;
            win     <= 1'b0;
            lose    <= 1'b0;
            busy    <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if ((work != prev_r) && has_zero) state <= SCAN;
          else                              state <= EVAL;
        end
        SCAN: begin
          // terminates within 16 cycles since CHECK saw an empty cell
          if (cur_cell == '0) state <= PLACE;
          else                ptr   <= ptr + 4'd1;
        end
        PLACE: begin
`ifdef SPAWN_FOUR_EN
          work[ptr[3:2]][ptr[1:0]] <= val_sel ? VAL_W'(4) : VAL_W'(2);
`else
          work[ptr[3:2]][ptr[1:0]] <= VAL_W'(2);
`endif
          spawned <= 1'b1;
          state   <= EVAL;
        end
        EVAL: begin
          win   <= has_win;
          lose  <= !has_zero && !has_pair;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tile_spawner.md
Name: tile_spawner

Overview:
- Stage directly downstream of the movement FSM in the 2048 game logic.
- Consumes the post-move 4x4 board and the pre-move board, and detects whether the move changed anything.
- If the board changed, inserts one new tile (2, or optionally 4) into a pseudo-randomly chosen empty cell.
- Evaluates win/lose on the resulting board and hands the final board to the board-state register with a one-cycle done pulse.

Parameters:
- VAL_W, 12, bit width of one tile value.
- WIN_VALUE, 2048, tile value that asserts win.
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be nonzero.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- matrix_in  input  VAL_W x [3:0][3:0]  post-move board (movement FSM output).
- matrix_prev  input  VAL_W x [3:0][3:0]  board before the move.
- matrix_out  output  VAL_W x [3:0][3:0]  resulting board; valid when done=1, held until next start.
- done  output  1  one-cycle pulse, result valid.
- busy  output  1  high in every state except IDLE.
- spawned  output  1  a tile was inserted in this operation.
- win  output  1  some cell of result == WIN_VALUE.
- lose  output  1  result has no zero cell and no horizontally/vertically adjacent equal pair.

Behaviour:
- Reset values:
  - matrix_out all 0; done, busy, spawned, win, lose all 0; state IDLE; LFSR = LFSR_SEED.
  - Reset in any state aborts the operation; done does not pulse.
- Cell index p[3:0]: row = p[3:2], col = p[1:0], cell = matrix[row][col].
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Each cycle: q <= {q[14:0], q[15]^q[13]^q[12]^q[10]}.
  - Free-runs every non-reset cycle regardless of state.
- IDLE:
  - busy=0.
  - On start=1: work <= matrix_in; prev_r <= matrix_prev; ptr <= lfsr[3:0]; val_sel <= (lfsr[7:5]==0).
  - Clear spawned, win and lose; go to CHECK.
  - start=0: stay in IDLE.
- CHECK (1 cycle):
  - changed = (work != prev_r), compared over all 16 cells.
  - changed and at least one zero cell: go to SCAN.
  - Otherwise go to EVAL; no spawn.
- SCAN (1 cycle per cell examined):
  - work[ptr]==0: go to PLACE.
  - Otherwise ptr <= ptr+1, wrapping 15 -> 0.
  - Bounded at 16 cycles because CHECK guaranteed an empty cell.
- PLACE (1 cycle):
  - work[ptr] <= tile value (2, or 4 per the optional feature); spawned <= 1; go to EVAL.
- EVAL (1 cycle):
  - win <= any cell == WIN_VALUE.
  - lose <= no zero cell and no equal adjacent pair among the 24 adjacencies.
  - Go to DONE.
- DONE (1 cycle):
  - done=1; go to IDLE.
- matrix_out is driven from work at all times; only guaranteed meaningful when done=1 or later in IDLE.
- Latency, start sampled at edge k:
  - No spawn: done high in cycle k+3.
  - Spawn: done high in cycle k+5+n, where n = occupied cells skipped (0..15).
  - Maximum latency 20 cycles.
- start while busy=1 is ignored, not queued.
- start in the DONE cycle is ignored; earliest accepted start is the cycle after done.
- win and lose are both evaluated and may both be 1.
- Tile arithmetic: values are stored, never summed here; no overflow is possible.

Optional Feature:
- Macro: SPAWN_FOUR_EN.
- Defined: PLACE writes 4 when val_sel=1 (probability 1/8), else writes 2.
- Undefined: PLACE always writes 2; val_sel is not implemented.

Test Plan:
- Reset mid-operation: assert rst for 2 cycles, start in SCAN -> all outputs 0 next cycle, busy=0, no done pulse; LFSR sequence restarts at 16'hACE1.
- Unchanged move: matrix_in == matrix_prev == full checkerboard of 2/4 -> done at k+3, spawned=0, lose=1, win=0, matrix_out == matrix_in.
- Single empty cell:
  - matrix_in has only [2][1]==0; neighbours of [2][1] are 8,16,32,64; no equal adjacent pair elsewhere; matrix_prev differs -> matrix_out[2][1]==2 (2 or 4 with SPAWN_FOUR_EN), all other cells unchanged.
  - Also check spawned=1 and lose=1.
- Empty board spawn:
  - matrix_in all 0, matrix_prev[0][0]=2 -> done at exactly k+5 with exactly one nonzero cell at index equal to the lfsr[3:0] captured at start.
  - Also check lose=0.
- Win detect: matrix_in[0][0]=2048, matrix_prev differs, at least one empty cell -> win=1, spawned=1, done pulses once.
- Busy rejection: pulse start again during SCAN with different matrix_in -> ignored; result reflects the first request; exactly one done pulse.
